if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch front end of the pipeline, directly upstream of the IF/ID pipeline register. Owns the program counter, issues in-order requests to instruction memory under a latency-tolerant request/response handshake, buffers returned words in a small FIFO, and presents one {PC+4, instruction} pair per cycle to the IF/ID register. Redirects on taken branches, discards stale in-flight responses, and holds its output under pipeline freeze.

## Interface
- N, 32: address/instruction width.
- DEPTH, 2: fetch FIFO entries; also the maximum number of in-flight requests plus buffered words (credit limit). Legal values: 2 or 4.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  hazard stall; output pair is held, not consumed.
- branch_taken  in  1  redirect request from the execute stage.
- branch_address  in  N  redirect target; word aligned.
- imem_req  out  1  fetch request valid.
- imem_addr  out  N  fetch address; valid while imem_req is high.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; responses return in request order, latency 1 or more cycles after grant.
- imem_rdata  in  N  instruction word.
- pc_out  out  N  address of the delivered instruction + 4; feeds pc_in of IF/ID.
- instruction_out  out  N  delivered instruction; feeds instruction_in of IF/ID.
- valid_out  out  1  pc_out and instruction_out hold a real instruction.

## Operation
- fetch_pc register: next address to request. A request is issued when credit is available: outstanding + fifo_count < DEPTH and branch_taken is low. imem_req and imem_addr are combinational from state.
- Request handshake: a request completes at a posedge where imem_req and imem_gnt are both high. On completion, fetch_pc advances by 4 and outstanding increments. With imem_gnt low, imem_addr holds stable.
- Response: when imem_rvalid is high, decrement outstanding (or discard). If discard_cnt is nonzero, decrement discard_cnt and drop the word. Otherwise push {address + 4, imem_rdata} into the FIFO. The address for each pushed word comes from a response-PC counter that tracks the request stream.
- Output: the FIFO head drives the outputs when the FIFO is non-empty (valid_out = 1). When the FIFO is empty, outputs are pc_out = 0, instruction_out = 0 (NOP), valid_out = 0.
- Consume: the head is popped at a posedge where valid_out = 1 and freeze = 0. While freeze = 1, outputs are held.
- Redirect on branch_taken:
  - fetch_pc and the response-PC counter load branch_address.
  - The FIFO is flushed.
  - discard_cnt loads outstanding minus any response arriving in that cycle; the outstanding count is kept.
  - imem_req is forced low for that cycle.
- Simultaneous events:
  - branch_taken overrides freeze, pop, and push.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - A grant and a response in the same cycle leave outstanding unchanged.
- Arithmetic: every PC add is modulo 2^N. Fetch wraps from 32'hFFFF_FFFC to 0 with no special handling.
- Reset: fetch_pc = RESET_PC; outstanding, discard_cnt, and FIFO all cleared; outputs 0, 0, 0. Reset asserted with requests in flight abandons them. The memory is required to be reset concurrently.

## Timing
- Reset values: imem_req = 1 in the first cycle after rst deasserts, with imem_addr = RESET_PC; pc_out = 0; instruction_out = 0; valid_out = 0.
- Fetch latency: grant at edge T, rvalid during cycle T+L, word on the outputs from cycle T+L+1. There is no FIFO bypass.
- Redirect in cycle R: first request to the target in cycle R+1. With a 1-cycle memory, the target instruction is on the outputs in cycle R+3. valid_out is 0 from cycle R+1 until then.
- Steady state with a 1-cycle memory and DEPTH = 2: one instruction per cycle.

## Configuration
- IF_PERF_CNT_EN defined: adds outputs fetch_count [31:0] and discard_count [31:0].
  - fetch_count increments per FIFO pop; discard_count increments per dropped response.
  - Both are cleared by reset and saturate at all-ones.
- IF_PERF_CNT_EN undefined: these ports and their counters do not exist; all other behaviour is identical.

## Structure
- Shared package if_pkg:
  - PC_STEP = 4.
  - NOP_INSTR = all-zero instruction.
  - RESET_PC default.
  - fetch_entry_t = {pc4 [N-1:0], instr [N-1:0]}.
- One sub-module: if_fetch_fifo, a DEPTH-entry synchronous FIFO with push, pop, flush, count, and head.
- Credit, discard, and PC logic stay in if_fetch_unit.

## Test plan
- Reset release, memory with 1-cycle latency and gnt tied high:
  - imem_addr sequence is 0x0, 0x4, 0x8.
  - Outputs: (0x4, word@0x0) in cycle 3, then one per cycle.
- freeze held high for 3 cycles with a full FIFO:
  - Output pair is unchanged.
  - imem_req = 0 once credit is exhausted.
  - After release, the next pair follows with no skip or duplicate.
- branch_taken to 0x100 with 2 requests outstanding:
  - Both stale responses are dropped (discard_count = 2 when the macro is enabled).
  - valid_out = 0 until (0x104, word@0x100).
- branch_taken and freeze in the same cycle with the FIFO full: the FIFO is flushed and fetch restarts at branch_address.
- imem_gnt low for 4 cycles, then variable response latency of 1–3 cycles: imem_addr is stable while ungranted, order is preserved, and outstanding + fifo_count never exceeds DEPTH.
- Wrap and reset: redirect to 0xFFFF_FFFC gives pc_out = 0x0000_0000 and the next fetch at 0x0. Reset asserted mid-stream forces all outputs to 0 immediately.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared constants and types for the instruction-fetch front end
package if_pkg;
    localparam int               XLEN             = 32;
    localparam logic [XLEN-1:0]  PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0]  NOP_INSTR        = '0;
    localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory request/response bus
interface if_fetch_unit_if
    import if_pkg::*;
#(
    parameter int N = XLEN
);
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [N-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_gnt, input imem_rvalid, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_gnt, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: DEPTH-entry synchronous FIFO with flush, occupancy count and head output
module if_fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;

    // pointer and occupancy update; flush empties the FIFO in one cycle
    always_comb begin
        rd_d    = flush_i ? '0 : rd_q + AW'(pop_i);
        wr_d    = flush_i ? '0 : wr_q + AW'(push_i);
        count_d = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    end

    // storage array holds data only, so it needs no reset
    always_ff @(posedge clk)
        if (push_i && !flush_i) mem_q[wr_q] <= din_i;

    // pointer and count registers
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, credit-limited imem fetch, stale-response discard and IF/ID feed (option: IF_PERF_CNT_EN)
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int           N        = XLEN,
    parameter int           DEPTH    = 2,
    parameter logic [N-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            freeze,
    input  logic            branch_taken,
    input  logic [N-1:0]    branch_address,
    if_fetch_unit_if.master imem,
    output logic [N-1:0]    pc_out,
    output logic [N-1:0]    instruction_out,
    output logic            valid_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     discard_count
`endif
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, resp_pc4;
    logic [CW-1:0]  out_q, out_d, disc_q, disc_d, fifo_count;
    logic [CW:0]    in_use;
    logic [2*N-1:0] head;
    logic           pop, push, drop, gnt_fire;

    // credit check, handshake, response routing and next state; a pop at this edge frees its slot
    always_comb begin
        valid_out       = fifo_count != '0;
        pop             = valid_out && !freeze && !branch_taken;
        in_use          = {1'b0, out_q} + {1'b0, fifo_count} - (CW+1)'(pop);
        imem.imem_req   = !branch_taken && (in_use < (CW+1)'(DEPTH));
        imem.imem_addr  = fetch_pc_q;
        gnt_fire        = imem.imem_req && imem.imem_gnt;
        drop            = imem.imem_rvalid && (branch_taken || disc_q != '0);
        push            = imem.imem_rvalid && !drop;
        resp_pc4        = resp_pc_q + N'(PC_STEP);
        out_d           = out_q + CW'(gnt_fire) - CW'(imem.imem_rvalid);
        disc_d          = branch_taken ? out_q - CW'(imem.imem_rvalid) : disc_q - CW'(drop);
        fetch_pc_d      = branch_taken ? branch_address : (gnt_fire ? fetch_pc_q + N'(PC_STEP) : fetch_pc_q);
        resp_pc_d       = branch_taken ? branch_address : (push ? resp_pc4 : resp_pc_q);
        pc_out          = valid_out ? head[2*N-1:N] : '0;
        instruction_out = valid_out ? head[N-1:0] : N'(NOP_INSTR);
    end

    // PC, in-flight and discard registers; reset abandons any in-flight requests
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
        end

    if_fetch_fifo #(.W(2*N), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (branch_taken),
        .din_i   ({resp_pc4, imem.imem_rdata}),
        .head_o  (head),
        .count_o (fifo_count)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, discard_cnt_q;

    // saturating counters of delivered instructions and dropped responses
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            fetch_cnt_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            if (pop && !(&fetch_cnt_q)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (drop && !(&discard_cnt_q)) discard_cnt_q <= discard_cnt_q + 32'd1;
        end

    assign fetch_count   = fetch_cnt_q;
    assign discard_count = discard_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized memory/pipeline stimulus checked every cycle against a queue-based model
module tb_if_fetch_unit;
    import if_pkg::*;
    localparam int DEPTH = 2;

    logic        clk = 1'b0, rst = 1'b0, freeze = 1'b0, branch_taken = 1'b0;
    logic [31:0] branch_address = '0;
    logic [31:0] pc_out, instruction_out;
    logic        valid_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count, discard_count;
`endif

    if_fetch_unit_if bus ();

    if_fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_address  (branch_address),
        .imem            (bus),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .discard_count   (discard_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t        pend[$];
    logic [31:0]  inf[$];
    fetch_entry_t mq[$];
    logic [31:0]  m_fetch;
    int           stale_n, m_pops, m_drops, cyc, npass, ntotal;
    int           gnt_pct = 100, lat_lo = 1, lat_hi = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic model_reset();
        pend.delete();
        inf.delete();
        mq.delete();
        stale_n = 0;
        m_pops  = 0;
        m_drops = 0;
        m_fetch = 32'h0;
    endtask

    task automatic step(input logic frz, input logic br, input logic [31:0] ba);
        logic        rv, gnt, exp_req, exp_valid, pop_m, dut_req;
        logic [31:0] dut_addr, a, exp_pc, exp_ins;
        freeze         = frz;
        branch_taken   = br;
        branch_address = ba;
        gnt            = $urandom_range(99) < gnt_pct;
        rv             = pend.size() > 0 && pend[0].due <= cyc;
        bus.imem_gnt   = gnt;
        bus.imem_rvalid = rv;
        if (rv) bus.imem_rdata = mem_word(pend[0].addr);
        else bus.imem_rdata = $urandom;
        #1;
        exp_valid = mq.size() > 0;
        exp_pc    = 32'h0;
        exp_ins   = 32'h0;
        if (exp_valid) begin
            exp_pc  = mq[0].pc4;
            exp_ins = mq[0].instr;
        end
        pop_m   = exp_valid && !frz && !br;
        exp_req = !br && (inf.size() + mq.size() - int'(pop_m)) < DEPTH;
        dut_req  = bus.imem_req;
        dut_addr = bus.imem_addr;
        chk("valid_out", 32'(valid_out), 32'(exp_valid));
        chk("pc_out", pc_out, exp_pc);
        chk("instruction_out", instruction_out, exp_ins);
        chk("imem_req", 32'(dut_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", dut_addr, m_fetch);
`ifdef IF_PERF_CNT_EN
        chk("fetch_count", fetch_count, 32'(m_pops));
        chk("discard_count", discard_count, 32'(m_drops));
`endif
        @(posedge clk);
        if (rv) void'(pend.pop_front());
        if (dut_req && gnt) pend.push_back('{dut_addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
        if (br) begin
            if (rv) begin
                void'(inf.pop_front());
                m_drops++;
            end
            stale_n = inf.size();
            mq.delete();
            m_fetch = ba;
        end else begin
            if (pop_m) begin
                void'(mq.pop_front());
                m_pops++;
            end
            if (rv) begin
                a = inf.pop_front();
                if (stale_n > 0) begin
                    stale_n--;
                    m_drops++;
                end else mq.push_back('{pc4: a + 32'd4, instr: mem_word(a)});
            end
            if (exp_req && gnt) begin
                inf.push_back(m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_instr", instruction_out, 32'h0);
        model_reset();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        freeze          = 1'b0;
        branch_taken    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        fetch_entry_t saved;
        logic [31:0]  tgt, a0;
        int           drops0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        npass  = 0;
        ntotal = 0;
        cyc    = 0;
        drops0 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(valid_out), 32'd0);
        chk("reset_pc_out", pc_out, 32'h0);
        chk("reset_instr", instruction_out, 32'h0);
        chk("reset_addr", bus.imem_addr, 32'h0);
        rst = 1'b1;

        chk("boot_req", 32'(bus.imem_req), 32'd1);
        step(1'b0, 1'b0, 32'h0);
        chk("boot_addr1", bus.imem_addr, 32'h4);
        step(1'b0, 1'b0, 32'h0);
        chk("boot_addr2", bus.imem_addr, 32'h8);
        chk("boot_valid", 32'(valid_out), 32'd1);
        chk("boot_pc0", pc_out, 32'h4);
        chk("boot_ins0", instruction_out, mem_word(32'h0));
        step(1'b0, 1'b0, 32'h0);
        chk("boot_pc1", pc_out, 32'h8);
        chk("boot_ins1", instruction_out, mem_word(32'h4));
        repeat (6) step(1'b0, 1'b0, 32'h0);

        saved = mq[0];
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("freeze_req_low", 32'(bus.imem_req), 32'd0);
        chk("freeze_hold", pc_out, saved.pc4);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("freeze_next", pc_out, saved.pc4 + 32'd4);
        repeat (3) step(1'b0, 1'b0, 32'h0);

        lat_lo = 3;
        lat_hi = 3;
        for (int i = 0; i < 20 && inf.size() != 2; i++) step(1'b0, 1'b0, 32'h0);
        drops0 = m_drops;
        step(1'b0, 1'b1, 32'h100);
        for (int i = 0; i < 20 && mq.size() == 0; i++) step(1'b0, 1'b0, 32'h0);
        chk("branch_pc", pc_out, 32'h104);
        chk("branch_ins", instruction_out, mem_word(32'h100));
`ifdef IF_PERF_CNT_EN
        chk("branch_discards", discard_count - 32'(drops0), 32'd2);
`endif

        lat_lo = 1;
        lat_hi = 1;
        for (int i = 0; i < 20 && mq.size() != DEPTH; i++) step(1'b1, 1'b0, 32'h0);
        tgt = $urandom & 32'hFFFF_FFFC;
        step(1'b1, 1'b1, tgt);
        chk("brfrz_flush", 32'(valid_out), 32'd0);
        chk("brfrz_addr", bus.imem_addr, tgt);
        repeat (5) step(1'b0, 1'b0, 32'h0);

        gnt_pct = 0;
        lat_hi  = 3;
        a0      = m_fetch;
        repeat (4) step(1'b0, 1'b0, 32'h0);
        chk("nognt_addr_hold", bus.imem_addr, a0);
        gnt_pct = 70;
        repeat (400) step($urandom_range(3) == 0, $urandom_range(24) == 0, $urandom & 32'hFFFF_FFFC);

        gnt_pct = 100;
        lat_hi  = 1;
        repeat (8) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_next_addr", bus.imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_valid", 32'(valid_out), 32'd1);
        chk("wrap_pc_out", pc_out, 32'h0);
        chk("wrap_ins", instruction_out, mem_word(32'hFFFF_FFFC));

        gnt_pct = 70;
        lat_hi  = 3;
        repeat (10) step($urandom_range(3) == 0, 1'b0, 32'h0);
        do_reset();
        chk("post_rst_addr", bus.imem_addr, 32'h0);
        chk("post_rst_req", 32'(bus.imem_req), 32'd1);
        gnt_pct = 100;
        lat_hi  = 1;
        repeat (20) step(1'b0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
